comm_master_nbyte: RTL and testbench

//  Parametrised command transmitter for the MazeRunner comm link.
//  - Accepts commands of CMD_BYTES bytes and queues them in a FIFO_DEPTH-entry command queue.
//  - Serialises each command byte-by-byte through the existing UART_tx, MSB- or LSB-first.
//  - Sits between the command source (test master / remote logic) and the TX pin.
//  - Multiple commands may be issued back-to-back without waiting for cmd_sent.

---
 rtl/comm_pkg.sv | 8 +
 rtl/UART_tx.sv | 52 +++++
 rtl/cmd_fifo.sv | 51 +++++
 rtl/comm_master_nbyte.sv | 103 ++++++++++
 tb/tb_comm_master_nbyte.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the MazeRunner command transmitter.
package comm_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD, XMIT, WAIT} cm_state_t;

endpackage

// File: rtl/UART_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; tx_done pulses for one cycle at the end.
module UART_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [8:0]    shft;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          active;

    assign TX = shft[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft     <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            active   <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt) begin
                shft     <= {tx_data, 1'b0};
                bit_cnt  <= '0;
                baud_cnt <= '0;
                active   <= 1'b1;
            end else if (active) begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt <= '0;
                    shft     <= {1'b1, shft[8:1]};
                    bit_cnt  <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        active  <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO. A push is refused while full, even if a pop
// happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; empty/full come from the reset counters, so stale data is never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/comm_master_nbyte.sv
// Command transmitter: queues CMD_BYTES-wide commands and sends each one
// byte by byte through UART_tx, MSB- or LSB-byte first.
module comm_master_nbyte
    import comm_pkg::*;
#(
    parameter int CMD_BYTES  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int BAUD_DIV   = 2604
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [8*CMD_BYTES-1:0]          cmd,
    input  logic                            send_cmd,
    output logic                            cmd_rdy,
    output logic [$clog2(FIFO_DEPTH):0]     q_cnt,
    output logic                            ovfl,
    output logic                            TX,
    output logic                            cmd_sent,
    output logic                            busy
);
    localparam int CW  = BYTE_W * CMD_BYTES;
    localparam int BCW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(CMD_BYTES - 1);

    cm_state_t         state, nxt_state;
    logic [CW-1:0]     sh, fifo_rdata;
    logic [BCW-1:0]    byte_cnt;
    logic [BYTE_W-1:0] tx_data;
    logic              fifo_full, fifo_empty, pop, trmt, tx_done;
    logic              last_done, advance;

    assign cmd_rdy   = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign last_done = (state == WAIT) && tx_done && (byte_cnt == LAST_BYTE);
    assign advance   = (state == WAIT) && tx_done && (byte_cnt != LAST_BYTE);

    cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (send_cmd),
        .pop   (pop),
        .wdata (cmd),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (q_cnt)
    );

    UART_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // NOTE: default first, so every path assigns nxt_state and no latch is inferred.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (!fifo_empty) nxt_state = LOAD;
            LOAD:    nxt_state = WAIT;
            XMIT:    nxt_state = WAIT;
            WAIT:    if (tx_done) nxt_state = (byte_cnt == LAST_BYTE) ? IDLE : XMIT;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        trmt    = (state == LOAD) || (state == XMIT);
        busy    = (state != IDLE);
        tx_data = MSB_FIRST ? sh[CW-1 -: BYTE_W] : sh[BYTE_W-1:0];
    end

    // The next byte to send always sits at the sent end of sh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            byte_cnt <= '0;
            cmd_sent <= 1'b0;
            ovfl     <= 1'b0;
        end else begin
            ovfl <= send_cmd && fifo_full;
            if (pop) begin
                sh       <= fifo_rdata;
                byte_cnt <= '0;
            end else if (advance) begin
                sh       <= MSB_FIRST ? (sh << BYTE_W) : (sh >> BYTE_W);
                byte_cnt <= byte_cnt + BCW'(1);
            end
            if (state == LOAD)  cmd_sent <= 1'b0;
            else if (last_done) cmd_sent <= 1'b1;
        end
    end

endmodule

// File: tb/tb_comm_master_nbyte.sv
// Bench for comm_master_nbyte: a 2-byte MSB-first and a 3-byte LSB-first instance,
// with a UART receiver model decoding TX and a byte-order reference model.
module tb_comm_master_nbyte;

    localparam int BAUD   = 8;
    localparam int BUDGET = 4000;

    logic        clk, rst_n;
    logic [15:0] cmd_a;
    logic [23:0] cmd_b;
    logic        send_a, send_b;
    logic        rdy_a, rdy_b, ovfl_a, ovfl_b, tx_a, tx_b, sent_a, sent_b, busy_a, busy_b;
    logic [2:0]  qcnt_a, qcnt_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rx_a_q[$], rx_b_q[$], exp_a[$], exp_b[$];

    comm_master_nbyte #(.CMD_BYTES(2), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .BAUD_DIV(BAUD)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_a), .send_cmd(send_a), .cmd_rdy(rdy_a),
        .q_cnt(qcnt_a), .ovfl(ovfl_a), .TX(tx_a), .cmd_sent(sent_a), .busy(busy_a)
    );

    comm_master_nbyte #(.CMD_BYTES(3), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .BAUD_DIV(BAUD)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_b), .send_cmd(send_b), .cmd_rdy(rdy_b),
        .q_cnt(qcnt_b), .ovfl(ovfl_b), .TX(tx_b), .cmd_sent(sent_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART receivers: sample mid-bit, drop any frame touched by reset or lacking a stop bit.
    always begin : rx_a
        logic [7:0] b;
        logic       ok;
        @(negedge clk);
        if (rst_n && tx_a == 1'b0) begin
            ok = 1'b1;
            repeat (BAUD/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = tx_a;
                ok &= rst_n;
            end
            repeat (BAUD) @(negedge clk);
            if (ok && rst_n && tx_a) rx_a_q.push_back(b);
        end
    end

    always begin : rx_b
        logic [7:0] b;
        logic       ok;
        @(negedge clk);
        if (rst_n && tx_b == 1'b0) begin
            ok = 1'b1;
            repeat (BAUD/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = tx_b;
                ok &= rst_n;
            end
            repeat (BAUD) @(negedge clk);
            if (ok && rst_n && tx_b) rx_b_q.push_back(b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte k of a command is (c >> 8k); MSB-first sends k = N-1..0.
    task automatic model_push(input bit wb, input logic [31:0] c);
        int n = wb ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            int k = wb ? i : (n - 1 - i);
            logic [7:0] v = 8'((c >> (8 * k)) & 32'hFF);
            if (wb) exp_b.push_back(v);
            else    exp_a.push_back(v);
        end
    endtask

    task automatic send(input bit wb, input logic [31:0] c);
        @(negedge clk);
        if (wb) begin cmd_b = c[23:0]; send_b = 1'b1; end
        else    begin cmd_a = c[15:0]; send_a = 1'b1; end
        @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
    endtask

    task automatic wait_idle(input bit wb, input string tag);
        bit done = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            done = wb ? (!busy_b && qcnt_b == 3'd0 && sent_b) : (!busy_a && qcnt_a == 3'd0 && sent_a);
        end
        check({tag, "_idle"}, done, 1);
    endtask

    task automatic wait_tx_done(input int n, input string tag);
        int seen = 0;
        for (int cyc = 0; cyc < BUDGET && seen < n; cyc++) begin
            @(negedge clk);
            if (dut_a.tx_done) seen++;
        end
        check({tag, "_txdone"}, seen, n);
    endtask

    task automatic compare_rx(input bit wb, input string tag);
        logic [7:0] e, g;
        int n = wb ? exp_b.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            if (wb) e = exp_b.pop_front();
            else    e = exp_a.pop_front();
            if ((wb ? rx_b_q.size() : rx_a_q.size()) == 0) begin
                check({tag, "_missing"}, 32'h100, {24'h0, e});
            end else begin
                if (wb) g = rx_b_q.pop_front();
                else    g = rx_a_q.pop_front();
                check(tag, g, e);
            end
        end
        check({tag, "_extra"}, wb ? rx_b_q.size() : rx_a_q.size(), 0);
    endtask

    typedef struct {
        bit              wb;
        logic [23:0]     cmd;
        int              n;
        logic [0:2][7:0] bytes;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int prev, ndec, nb;
        bit done;
        logic [31:0] c;

        tbl[0] = '{wb: 1'b0, cmd: 24'h000001, n: 2, bytes: {8'h00, 8'h01, 8'h00}};
        tbl[1] = '{wb: 1'b0, cmd: 24'h00FF00, n: 2, bytes: {8'hFF, 8'h00, 8'h00}};
        tbl[2] = '{wb: 1'b0, cmd: 24'h008001, n: 2, bytes: {8'h80, 8'h01, 8'h00}};
        tbl[3] = '{wb: 1'b1, cmd: 24'h123456, n: 3, bytes: {8'h56, 8'h34, 8'h12}};
        tbl[4] = '{wb: 1'b1, cmd: 24'hFFFFFF, n: 3, bytes: {8'hFF, 8'hFF, 8'hFF}};
        tbl[5] = '{wb: 1'b1, cmd: 24'h00A5C3, n: 3, bytes: {8'hC3, 8'hA5, 8'h00}};

        rst_n = 1'b0; send_a = 1'b0; send_b = 1'b0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1);     check("rst_tx_b", tx_b, 1);
        check("rst_sent_a", sent_a, 0); check("rst_sent_b", sent_b, 0);
        check("rst_rdy_a", rdy_a, 1);   check("rst_rdy_b", rdy_b, 1);
        check("rst_qcnt_a", qcnt_a, 0); check("rst_qcnt_b", qcnt_b, 0);
        check("rst_busy_a", busy_a, 0); check("rst_busy_b", busy_b, 0);
        check("rst_ovfl_a", ovfl_a, 0); check("rst_ovfl_b", ovfl_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A55A: latency to trmt and cmd_sent timing after the final tx_done.
        cmd_a = 16'hA55A; send_a = 1'b1;
        @(negedge clk); send_a = 1'b0;
        check("lat1_trmt", dut_a.trmt, 0); check("lat1_qcnt", qcnt_a, 1);
        @(negedge clk);
        check("lat2_trmt", dut_a.trmt, 1); check("lat2_busy", busy_a, 1); check("lat2_qcnt", qcnt_a, 0);
        wait_tx_done(2, "a55a");
        check("a55a_sent_on_done", sent_a, 0);
        @(negedge clk);
        check("a55a_sent_after", sent_a, 1);
        model_push(1'b0, 32'hA55A);
        wait_idle(1'b0, "a55a");
        compare_rx(1'b0, "a55a_byte");

        // Table-driven single commands on both byte orders.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].wb, {8'h0, tbl[i].cmd});
            wait_idle(tbl[i].wb, "tbl");
            for (int j = 0; j < tbl[i].n; j++) begin
                if (tbl[i].wb) exp_b.push_back(tbl[i].bytes[j]);
                else           exp_a.push_back(tbl[i].bytes[j]);
            end
            compare_rx(tbl[i].wb, $sformatf("tbl%0d_byte", i));
        end

        // Overflow: one command in flight, then five back-to-back pushes.
        send(1'b0, 32'h0000);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("ovf_rdy_before%0d", i), rdy_a, (i <= 4) ? 1 : 0);
            cmd_a = 16'(16'h1111 * i); send_a = 1'b1;
            @(negedge clk);
            if (i == 4) begin check("ovf_rdy_full", rdy_a, 0); check("ovf_qcnt_full", qcnt_a, 4); end
            if (i == 5) begin check("ovf_pulse", ovfl_a, 1); check("ovf_qcnt_keep", qcnt_a, 4); end
        end
        send_a = 1'b0;
        @(negedge clk);
        check("ovf_pulse_end", ovfl_a, 0);
        prev = 4; ndec = 0; done = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            if (int'(qcnt_a) != prev) begin
                check("ovf_qdec", qcnt_a, prev - 1);
                check("ovf_qdec_load", dut_a.trmt, 1);
                prev = int'(qcnt_a);
                ndec++;
            end
            done = !busy_a && qcnt_a == 3'd0 && sent_a;
        end
        check("ovf_ndec", ndec, 4);
        for (int i = 0; i <= 4; i++) model_push(1'b0, 32'h1111 * i);
        compare_rx(1'b0, "ovf_byte");

        // Push on the cycle of the final tx_done of a prior command.
        send(1'b0, 32'h1234);
        wait_tx_done(2, "b2b");
        cmd_a = 16'hBEEF; send_a = 1'b1;
        @(negedge clk); send_a = 1'b0;
        check("b2b_sent_rise", sent_a, 1); check("b2b_busy_idle", busy_a, 0); check("b2b_qcnt", qcnt_a, 1);
        @(negedge clk);
        check("b2b_sent_load", sent_a, 1); check("b2b_trmt_load", dut_a.trmt, 1);
        @(negedge clk);
        check("b2b_sent_fall", sent_a, 0);
        model_push(1'b0, 32'h1234); model_push(1'b0, 32'hBEEF);
        wait_idle(1'b0, "b2b");
        compare_rx(1'b0, "b2b_byte");

        // Reset in the second byte with two commands queued.
        send(1'b0, 32'h1111); send(1'b0, 32'h2222); send(1'b0, 32'h3333);
        wait_tx_done(1, "mrst");
        repeat (3 * BAUD) @(negedge clk);
        check("mrst_qcnt_pre", qcnt_a, 2);
        rst_n = 1'b0;
        #1;
        check("mrst_tx", tx_a, 1); check("mrst_busy", busy_a, 0); check("mrst_qcnt", qcnt_a, 0);
        check("mrst_rdy", rdy_a, 1); check("mrst_sent", sent_a, 0);
        repeat (12 * BAUD) @(negedge clk);
        rst_n = 1'b1;
        rx_a_q.delete(); rx_b_q.delete(); exp_a.delete(); exp_b.delete();
        @(negedge clk);
        send(1'b0, 32'hC3C3);
        model_push(1'b0, 32'hC3C3);
        wait_idle(1'b0, "mrst");
        compare_rx(1'b0, "mrst_byte");

        // Random bursts of up to FIFO_DEPTH commands with random gaps.
        for (int it = 0; it < 16; it++) begin
            bit wb = 1'(it % 2);
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                c = $urandom;
                check("rnd_rdy", wb ? rdy_b : rdy_a, 1);
                send(wb, c);
                model_push(wb, c);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle(wb, "rnd");
            check("rnd_no_ovfl", wb ? ovfl_b : ovfl_a, 0);
            compare_rx(wb, $sformatf("rnd%0d_byte", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
